// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared constants and boot program for instruction_mem
// Purpose: default geometry, NOP / reset-output constants and the boot image.
// Ports: none (package).
package instr_mem_pkg;

  localparam int DEPTH_DEFAULT = 64;
  localparam int WIDTH_DEFAULT = 32;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] RESET_OUT = 32'h0000_0000;

  localparam int BOOT_LEN = 6;
  localparam logic [31:0] BOOT_PROG [BOOT_LEN] = '{
    32'h0050_0093,  // addi x1,x0,5
    32'h00A0_0113,  // addi x2,x0,10
    32'h0020_81B3,  // add  x3,x1,x2
    32'h4020_8233,  // sub  x4,x1,x2
    32'h0020_F2B3,  // and  x5,x1,x2
    32'h0020_E333   // or   x6,x1,x2
  };

  // Image word for a given index: boot program first, NOP fill after it.
  function automatic logic [31:0] boot_word(input int unsigned idx);
    logic [31:0] w;
    w = NOP;
    if (idx < BOOT_LEN) w = BOOT_PROG[idx[2:0]];
    return w;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// rtl/reset_sync.sv - two-flop async-assert / sync-deassert reset release
// Purpose: produces a release flag that drops immediately with reset and
//          rises only after two rising clk edges with reset high.
// Ports: clk (in), reset (in, active-low async), released (out, high = run).
module reset_sync (
  input  logic clk,
  input  logic reset,
  output logic released
);

  logic [1:0] sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= 2'b00;
    else        sync <= {sync[0], 1'b1};
  end

  assign released = sync[1];

endmodule

// File: rtl/instruction_mem.sv
// rtl/instruction_mem.sv - read-only instruction store with boot image
// Purpose: DEPTH x WIDTH instruction array, loaded with the boot program while
//          reset is low and read combinationally by word index.
// Ports: clk (in), reset (in, active-low async), read_address (in, 32-bit word
//        index), instruction_out (out, WIDTH-bit instruction word).
module instruction_mem
  import instr_mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      read_address,
  output logic [WIDTH-1:0] instruction_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             released;
  logic             in_range;
  logic [AW-1:0]    idx;

  reset_sync u_reset_sync (
    .clk      (clk),
    .reset    (reset),
    .released (released)
  );

  // Contents are only ever written by reset, so every reset reproduces the
  // same image and clock edges leave it untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= WIDTH'(boot_word(i));
      end
    end
  end

  // Full 32-bit compare so high address bits never alias back into the array.
  assign in_range = (read_address < 32'(DEPTH));
  assign idx      = read_address[AW-1:0];

  // Raw reset gates the output at once; the synchronized flag holds it off
  // until two clean edges after release.
  always_comb begin
    instruction_out = WIDTH'(RESET_OUT);
    if (reset && released) begin
      instruction_out = in_range ? mem[idx] : WIDTH'(NOP);
    end
  end

endmodule

// File: tb/tb_instruction_mem.sv
// tb/tb_instruction_mem.sv - self-checking scoreboard bench for instruction_mem
module tb_instruction_mem;

  logic        clk;
  logic        reset;
  logic [31:0] read_address;
  logic [31:0] instruction_out;

  int n_checks;
  int n_fail;

  logic [31:0] exp_q [$];

  localparam logic [31:0] EXP_NOP = 32'h0000_0013;
  logic [31:0] boot [6];

  instruction_mem #(.DEPTH(64), .WIDTH(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .read_address    (read_address),
    .instruction_out (instruction_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model(input logic [31:0] a);
    if (a < 32'd6)  return boot[a[2:0]];
    return EXP_NOP;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Expected value recorded at drive time, popped when the output is sampled.
  task automatic expect_out(input string tag, input logic [31:0] want);
    logic [31:0] e;
    exp_q.push_back(want);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty got %h expected %h", tag, instruction_out, want);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, instruction_out, e);
    end
  endtask

  task automatic drive(input string tag, input logic [31:0] a, input logic [31:0] want);
    read_address = a;
    expect_out(tag, want);
  endtask

  initial begin
    logic [31:0] a;
    boot[0] = 32'h0050_0093;
    boot[1] = 32'h00A0_0113;
    boot[2] = 32'h0020_81B3;
    boot[3] = 32'h4020_8233;
    boot[4] = 32'h0020_F2B3;
    boot[5] = 32'h0020_E333;
    n_checks = 0;
    n_fail   = 0;

    // Reset held: output forced to zero whatever the address.
    reset        = 1'b0;
    read_address = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    drive("rst_addr0", 32'd0, 32'h0);
    drive("rst_addr3", 32'd3, 32'h0);

    // Release: gated until two edges, then word 0.
    read_address = 32'd0;
    reset        = 1'b1;
    expect_out("release_gated", 32'h0);
    repeat (2) @(posedge clk);
    expect_out("release_word0", boot[0]);

    // Boot program sweep, all changes within one low phase (no edges).
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      read_address = 32'(i);
      exp_q.push_back(model(32'(i)));
      #0.5;
      check_eq($sformatf("sweep_%0d", i), instruction_out, exp_q.pop_front());
    end

    // NOP fill and out-of-range addresses.
    @(negedge clk);
    drive("addr6",        32'd6,          EXP_NOP);
    drive("addr63",       32'd63,         EXP_NOP);
    drive("addr64",       32'd64,         EXP_NOP);
    drive("addr_ffff",    32'hFFFF_FFFF,  EXP_NOP);
    drive("addr128",      32'd128,        EXP_NOP);
    drive("addr_msb",     32'h8000_0000,  EXP_NOP);
    drive("addr_alias1",  32'd65,         EXP_NOP);

    // Random addresses against the model.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      a = (i % 2 == 0) ? 32'($urandom_range(0, 70)) : $urandom;
      drive("rand", a, model(a));
    end

    // Static address across 20 clocks.
    @(negedge clk);
    read_address = 32'd1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      expect_out("static_addr1", boot[1]);
    end

    // Address change between edges: 1 -> 5 without an edge.
    @(negedge clk);
    drive("between_1", 32'd1, boot[1]);
    drive("between_5", 32'd5, boot[5]);

    // Mid-period reset with address 5.
    @(posedge clk);
    #2;
    reset = 1'b0;
    expect_out("midrst_drop", 32'h0);
    repeat (2) @(posedge clk);
    #1;
    expect_out("midrst_held", 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    expect_out("midrst_word5", boot[5]);

    // Address change on the same step as reset release.
    @(negedge clk);
    reset = 1'b0;
    #1;
    reset        = 1'b1;
    read_address = 32'd4;
    repeat (2) @(posedge clk);
    expect_out("release_addr4", boot[4]);

    // Image identical after repeated resets.
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive("post_rst", 32'(i), model(32'(i)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
